mem_access: RTL and testbench

//  MEM pipeline stage, directly upstream of write-back.

---
 rtl/mem_access.sv | 182 ++++++++++++++++++
 tb/tb_mem_access.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM stage: turns a load/store into a data-bus request, aligns store data, checks alignment, owns the LL/SC link bit.
// Latency: the request issues in the same cycle the op is valid; an ack that same cycle completes with no added latency.
// Backpressure: stallreq holds the pipeline while a request waits for dbus_ack; fields stay stable until ack.
module mem_access #(
  parameter int ACK_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        adv,
  input  logic        flush,
  input  logic        llclr,
  input  logic [4:0]  aluop,
  input  logic [31:0] alures,
  input  logic [31:0] rt_data,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        dbus_req,
  output logic [3:0]  dbus_wen,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [31:0] m_vaddr,
  output logic [31:0] m_rdata,
  output logic [31:0] sc_res,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        stallreq
);

  localparam logic [4:0] ALU_LB  = 5'h10, ALU_LBU = 5'h11, ALU_LH  = 5'h12, ALU_LHU = 5'h13;
  localparam logic [4:0] ALU_LW  = 5'h14, ALU_LWL = 5'h15, ALU_LWR = 5'h16, ALU_LL  = 5'h17;
  localparam logic [4:0] ALU_SB  = 5'h18, ALU_SH  = 5'h19, ALU_SW  = 5'h1a, ALU_SWL = 5'h1b;
  localparam logic [4:0] ALU_SWR = 5'h1c, ALU_SC  = 5'h1d;
  localparam logic [31:0] TIMEOUT = ACK_TIMEOUT;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;
  state_t state, nxt;

  logic [31:0] rdata_q, addr_q, wdata_q, timer;
  logic [3:0]  wen_q;
  logic        llbit, ll_q, sc_q;

  logic        is_load, is_store, is_ll, is_sc, mis, memop, busy, live_ack;
  logic [1:0]  a;
  logic [3:0]  st_wen;
  logic [31:0] st_wdata;

  assign a       = alures[1:0];
  assign m_vaddr = alures;
  assign busy    = (state == WAIT) || (state == DRAIN);

  // Decode the op class, alignment fault, and lane-aligned store data/enables
  always_comb begin
    is_load  = (aluop >= ALU_LB) && (aluop <= ALU_LL);
    is_store = (aluop >= ALU_SB) && (aluop <= ALU_SC);
    is_ll    = (aluop == ALU_LL);
    is_sc    = (aluop == ALU_SC);
    mis      = 1'b0;
    st_wen   = 4'b0000;
    st_wdata = rt_data;
    case (aluop)
      ALU_LH, ALU_LHU:        mis = a[0];
      ALU_LW, ALU_LL:         mis = (a != 2'b00);
      ALU_SB: begin
        st_wen   = 4'b0001 << a;
        st_wdata = {4{rt_data[7:0]}};
      end
      ALU_SH: begin
        mis      = a[0];
        st_wen   = a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rt_data[15:0]}};
      end
      ALU_SW, ALU_SC: begin
        mis    = (a != 2'b00);
        st_wen = 4'b1111;
      end
      ALU_SWL: begin
        st_wen   = 4'b1111 >> (2'd3 - a);
        st_wdata = rt_data >> (8 * (2'd3 - a));
      end
      ALU_SWR: begin
        st_wen   = 4'b1111 << a;
        st_wdata = rt_data << (8 * a);
      end
      default: ;
    endcase
    // A failed SC never reaches the bus
    memop = valid && !flush && (is_load || is_store) && !mis && !(is_sc && !llbit);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: one request per instruction, drain a flushed request before reuse
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (memop) nxt = dbus_ack ? (adv ? IDLE : DONE) : WAIT;
      WAIT: begin
        if (dbus_ack)   nxt = (adv || flush) ? IDLE : DONE;
        else if (flush) nxt = DRAIN;
      end
      DONE:  if (adv || flush) nxt = IDLE;
      DRAIN: if (dbus_ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs: live fields when issuing from IDLE, captured fields while outstanding
  always_comb begin
    dbus_req   = 1'b0;
    dbus_addr  = addr_q;
    dbus_wen   = wen_q;
    dbus_wdata = wdata_q;
    stallreq   = 1'b0;
    sc_res     = {31'b0, sc_q};
    case (state)
      IDLE: begin
        dbus_req   = memop;
        dbus_addr  = {alures[31:2], 2'b00};
        dbus_wen   = st_wen;
        dbus_wdata = st_wdata;
        stallreq   = memop && !dbus_ack;
        sc_res     = {31'b0, memop && is_sc};
      end
      WAIT: begin
        dbus_req = 1'b1;
        stallreq = !dbus_ack;
      end
      DRAIN: begin
        dbus_req = 1'b1;
        stallreq = 1'b1;
      end
      default: ;
    endcase
    m_rdata  = (dbus_req && dbus_ack) ? dbus_rdata : rdata_q;
    exc_adel = valid && is_load && mis;
    exc_ades = valid && is_store && mis;
    bus_err  = busy && (TIMEOUT != 32'd0) && (timer == TIMEOUT);
  end

  // An ack that lands on a flushed or drained request updates nothing
  assign live_ack = dbus_req && dbus_ack && (state != DRAIN) && !flush;

  // Datapath: request capture, read data, link bit, ack timer
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wen_q   <= 4'd0;
      ll_q    <= 1'b0;
      sc_q    <= 1'b0;
      llbit   <= 1'b0;
      timer   <= 32'd0;
    end else begin
      if (state == IDLE && memop) begin
        addr_q  <= {alures[31:2], 2'b00};
        wen_q   <= st_wen;
        wdata_q <= st_wdata;
        ll_q    <= is_ll;
        sc_q    <= is_sc;
      end else if (state == DONE && (adv || flush)) begin
        sc_q    <= 1'b0;
      end
      if (live_ack) rdata_q <= dbus_rdata;
      // Clear beats set
      if (llclr || flush || (live_ack && ((state == IDLE) ? is_sc : sc_q)))
        llbit <= 1'b0;
      else if (live_ack && ((state == IDLE) ? is_ll : ll_q))
        llbit <= 1'b1;
      // Saturates one past the limit so bus_err pulses only once
      if (!busy || dbus_ack)       timer <= 32'd0;
      else if (timer <= TIMEOUT)   timer <= timer + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table for single-cycle issue, then hand sequences for multi-cycle cases.
module tb_mem_access;
  localparam logic [4:0] LB = 5'h10, LBU = 5'h11, LH = 5'h12, LHU = 5'h13, LW = 5'h14, LL = 5'h17;
  localparam logic [4:0] SB = 5'h18, SH = 5'h19, SW = 5'h1a, SWL = 5'h1b, SWR = 5'h1c, SC = 5'h1d;

  logic clk = 1'b0, rst, valid, adv, flush, llclr, dbus_ack;
  logic [4:0]  aluop;
  logic [31:0] alures, rt_data, dbus_rdata;
  logic        dbus_req, exc_adel, exc_ades, bus_err, stallreq;
  logic [3:0]  dbus_wen;
  logic [31:0] dbus_addr, dbus_wdata, m_vaddr, m_rdata, sc_res;

  int ntests = 0;
  int nfail  = 0;

  mem_access #(.ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .valid(valid), .adv(adv), .flush(flush), .llclr(llclr),
    .aluop(aluop), .alures(alures), .rt_data(rt_data), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .dbus_req(dbus_req), .dbus_wen(dbus_wen),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .m_vaddr(m_vaddr),
    .m_rdata(m_rdata), .sc_res(sc_res), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .bus_err(bus_err), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, rt;
    logic        req;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic        adel, ades, sc;
  } vec_t;

  function automatic vec_t mk(logic [4:0] op, logic [31:0] a, logic [31:0] rt, logic req,
                              logic [3:0] wen, logic [31:0] wdata, logic adel, logic ades, logic sc);
    vec_t v;
    v.op = op; v.a = a; v.rt = rt; v.req = req; v.wen = wen; v.wdata = wdata;
    v.adel = adel; v.ades = ades; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid = 0; adv = 1; flush = 0; llclr = 0; dbus_ack = 0;
    aluop = 5'h00; alures = 32'h0; rt_data = 32'h0; dbus_rdata = 32'h0;
  endtask

  task automatic op_in(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rt);
    valid = 1; aluop = op; alures = a; rt_data = rt;
  endtask

  vec_t tbl[16];
  int   stalls, errs, first_err;

  initial begin
    tbl[0]  = mk(LW,  32'h100, 32'h0,        1, 4'b0000, 32'h0,        0, 0, 0);
    tbl[1]  = mk(SB,  32'h103, 32'hA5,       1, 4'b1000, 32'hA5A5A5A5, 0, 0, 0);
    tbl[2]  = mk(SB,  32'h101, 32'h12345678, 1, 4'b0010, 32'h78787878, 0, 0, 0);
    tbl[3]  = mk(SH,  32'h202, 32'h1234BEEF, 1, 4'b1100, 32'hBEEFBEEF, 0, 0, 0);
    tbl[4]  = mk(SH,  32'h201, 32'h1234BEEF, 0, 4'b0000, 32'h0,        0, 1, 0);
    tbl[5]  = mk(LH,  32'h101, 32'h0,        0, 4'b0000, 32'h0,        1, 0, 0);
    tbl[6]  = mk(LW,  32'h102, 32'h0,        0, 4'b0000, 32'h0,        1, 0, 0);
    tbl[7]  = mk(SW,  32'h300, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D, 0, 0, 0);
    tbl[8]  = mk(SWL, 32'h301, 32'h11223344, 1, 4'b0011, 32'h00001122, 0, 0, 0);
    tbl[9]  = mk(SWR, 32'h302, 32'h11223344, 1, 4'b1100, 32'h33440000, 0, 0, 0);
    tbl[10] = mk(SWL, 32'h303, 32'h11223344, 1, 4'b1111, 32'h11223344, 0, 0, 0);
    tbl[11] = mk(SWR, 32'h300, 32'h11223344, 1, 4'b1111, 32'h11223344, 0, 0, 0);
    tbl[12] = mk(SC,  32'h400, 32'h55,       0, 4'b0000, 32'h0,        0, 0, 0);
    tbl[13] = mk(LHU, 32'h106, 32'h0,        1, 4'b0000, 32'h0,        0, 0, 0);
    tbl[14] = mk(5'h01, 32'h103, 32'h0,      0, 4'b0000, 32'h0,        0, 0, 0);
    tbl[15] = mk(LBU, 32'h107, 32'h0,        1, 4'b0000, 32'h0,        0, 0, 0);

    // Reset
    idle_in();
    rst = 1;
    step(); step();
    chk("rst_req", {31'b0, dbus_req}, 0);
    chk("rst_stall", {31'b0, stallreq}, 0);
    chk("rst_exc", {30'b0, exc_adel, exc_ades}, 0);
    chk("rst_buserr", {31'b0, bus_err}, 0);
    chk("rst_rdata", m_rdata, 0);
    rst = 0;
    step();

    // Single-cycle vectors: ack arrives with the request, pipeline advancing
    for (int i = 0; i < 16; i++) begin
      op_in(tbl[i].op, tbl[i].a, tbl[i].rt);
      dbus_ack = tbl[i].req;
      dbus_rdata = 32'hD0000000 + i;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, dbus_req}, {31'b0, tbl[i].req});
      chk($sformatf("v%0d_adel", i), {31'b0, exc_adel}, {31'b0, tbl[i].adel});
      chk($sformatf("v%0d_ades", i), {31'b0, exc_ades}, {31'b0, tbl[i].ades});
      chk($sformatf("v%0d_stall", i), {31'b0, stallreq}, 0);
      chk($sformatf("v%0d_sc", i), sc_res, {31'b0, tbl[i].sc});
      if (tbl[i].req) begin
        chk($sformatf("v%0d_wen", i), {28'b0, dbus_wen}, {28'b0, tbl[i].wen});
        chk($sformatf("v%0d_addr", i), dbus_addr, {tbl[i].a[31:2], 2'b00});
        chk($sformatf("v%0d_rdata", i), m_rdata, 32'hD0000000 + i);
        if (tbl[i].wen != 4'b0000)
          chk($sformatf("v%0d_wdata", i), dbus_wdata, tbl[i].wdata);
      end
      step();
    end
    idle_in();
    step();

    // SB acked 3 cycles after issue: fields held, stall for exactly 3 cycles
    stalls = 0;
    op_in(SB, 32'h103, 32'hA5);
    for (int c = 0; c < 4; c++) begin
      dbus_ack = (c == 3);
      dbus_rdata = 32'h0BAD0000;
      #1;
      chk($sformatf("sb_req%0d", c), {31'b0, dbus_req}, 1);
      chk($sformatf("sb_wen%0d", c), {28'b0, dbus_wen}, 32'h8);
      chk($sformatf("sb_wdata%0d", c), dbus_wdata, 32'hA5A5A5A5);
      if (stallreq) stalls++;
      step();
      rt_data = 32'h0;
    end
    chk("sb_stall_cycles", stalls, 3);
    idle_in();
    #1;
    chk("sb_after_req", {31'b0, dbus_req}, 0);
    step();

    // LW acked while the pipeline is stalled externally: one request, data retained
    op_in(LW, 32'h100, 32'h0);
    adv = 0; dbus_ack = 1; dbus_rdata = 32'h000055AA;
    #1;
    chk("done_ack_rdata", m_rdata, 32'h55AA);
    step();
    dbus_ack = 0; dbus_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      adv = (c == 1);
      #1;
      chk($sformatf("done_req%0d", c), {31'b0, dbus_req}, 0);
      chk($sformatf("done_stall%0d", c), {31'b0, stallreq}, 0);
      chk($sformatf("done_rdata%0d", c), m_rdata, 32'h55AA);
      step();
    end
    idle_in();
    step();

    // Flush while waiting: request drains, its data is discarded
    op_in(LW, 32'h600, 32'h0);
    #1;
    chk("fl_issue_stall", {31'b0, stallreq}, 1);
    step();
    flush = 1; valid = 0; alures = 32'h0;
    #1;
    chk("fl_wait_req", {31'b0, dbus_req}, 1);
    step();
    flush = 0;
    #1;
    chk("fl_drain_req", {31'b0, dbus_req}, 1);
    chk("fl_drain_addr", dbus_addr, 32'h600);
    chk("fl_drain_stall", {31'b0, stallreq}, 1);
    step();
    dbus_ack = 1; dbus_rdata = 32'h00000777;
    #1;
    chk("fl_ack_req", {31'b0, dbus_req}, 1);
    chk("fl_ack_stall", {31'b0, stallreq}, 1);
    step();
    dbus_ack = 0;
    #1;
    chk("fl_idle_req", {31'b0, dbus_req}, 0);
    chk("fl_idle_rdata", m_rdata, 32'h55AA);
    step();

    // LL then SC succeeds; a second SC fails
    op_in(LL, 32'h200, 32'h0);
    dbus_ack = 1; dbus_rdata = 32'h1;
    step();
    op_in(SC, 32'h204, 32'h99);
    dbus_ack = 0;
    #1;
    chk("sc_req", {31'b0, dbus_req}, 1);
    chk("sc_wen", {28'b0, dbus_wen}, 32'hF);
    chk("sc_wdata", dbus_wdata, 32'h99);
    chk("sc_res_issue", sc_res, 1);
    step();
    dbus_ack = 1;
    #1;
    chk("sc_res_ack", sc_res, 1);
    chk("sc_ack_stall", {31'b0, stallreq}, 0);
    step();
    dbus_ack = 0;
    #1;
    chk("sc2_req", {31'b0, dbus_req}, 0);
    chk("sc2_res", sc_res, 0);
    step();

    // llclr between LL and SC kills the SC
    op_in(LL, 32'h208, 32'h0);
    dbus_ack = 1;
    step();
    idle_in();
    llclr = 1;
    step();
    llclr = 0;
    op_in(SC, 32'h20C, 32'h1);
    #1;
    chk("llclr_req", {31'b0, dbus_req}, 0);
    chk("llclr_res", sc_res, 0);
    step();
    idle_in();
    step();

    // Ack timeout: one bus_err pulse after 8 full WAIT cycles, request held
    errs = 0; first_err = -1;
    op_in(LW, 32'h500, 32'h0);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 0 || c == 19) chk($sformatf("to_req%0d", c), {31'b0, dbus_req}, 1);
      if (bus_err) begin
        errs++;
        if (first_err < 0) first_err = c;
      end
      step();
    end
    chk("to_pulses", errs, 1);
    chk("to_first", first_err, 9);
    dbus_ack = 1;
    step();
    idle_in();
    #1;
    chk("to_end_req", {31'b0, dbus_req}, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
